serial_adder_ctrl: RTL and testbench

//   Bit-serial adder controller. Time-multiplexes one full-adder cell over a

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_ctrl_if.sv | 25 ++
 rtl/serial_adder_ctrl_full_adder_cell.sv | 19 +
 rtl/serial_adder_ctrl.sv | 147 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_if.sv
// Operand-intake / result-output bundle for serial_adder_ctrl.
// master = operand producer and result consumer, slave = the controller.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op;
   logic [WIDTH:0]   result;
   logic             result_valid;
   logic             result_ready;
   logic             busy;

   modport master (
      output start_valid, a, b, op, result_ready,
      input  start_ready, result, result_valid, busy
   );

   modport slave (
      input  start_valid, a, b, op, result_ready,
      output start_ready, result, result_valid, busy
   );
endinterface : serial_adder_ctrl_if

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// Single-bit full adder built from xor/and/or gates; carry is the majority
// of (a, b, cin) expressed as generate | (propagate & cin).
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic prop_s;
   logic gen_s;
   logic prop_c_s;

   xor u_xor_p (prop_s, a, b);
   xor u_xor_s (sum, prop_s, cin);
   and u_and_g (gen_s, a, b);
   and u_and_p (prop_c_s, prop_s, cin);
   or  u_or_c  (cout, gen_s, prop_c_s);
endmodule : full_adder_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell, LSB first, one bit per clock.
// Define SUBTRACT_EN to enable op=1 subtraction (a + ~b + 1).
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                reset,
   serial_adder_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH:0]   result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             start_ready_q, start_ready_d;
   logic             busy_q, busy_d;

   logic             fa_sum_s;
   logic             fa_cout_s;

   full_adder_cell u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum_s),
      .cout (fa_cout_s)
   );

   // Next-state and next-output computation for the IDLE/RUN/DONE sequence.
   always_comb begin
      state_d        = state_q;
      a_sh_d         = a_sh_q;
      b_sh_d         = b_sh_q;
      sum_sh_d       = sum_sh_q;
      carry_d        = carry_q;
      count_d        = count_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      start_ready_d  = start_ready_q;
      busy_d         = busy_q;

      case (state_q)
         IDLE: begin
            if (bus.start_valid) begin
               a_sh_d        = bus.a;
               sum_sh_d      = '0;
               count_d       = '0;
`ifdef SUBTRACT_EN
               if (bus.op) begin
                  b_sh_d  = ~bus.b;
                  carry_d = 1'b1;
               end else begin
                  b_sh_d  = bus.b;
                  carry_d = 1'b0;
               end
`else
               b_sh_d        = bus.b;
               carry_d       = 1'b0;
`endif
               state_d       = RUN;
               start_ready_d = 1'b0;
               busy_d        = 1'b1;
            end else begin
               start_ready_d = 1'b1;
               busy_d        = 1'b0;
            end
         end

         RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = fa_cout_s;
            count_d = count_q + CW'(1);
            for (int i = 0; i < WIDTH - 2; i++) begin
               sum_sh_d[i] = sum_sh_q[i+1];
            end
            sum_sh_d[WIDTH-2] = fa_sum_s;
            if (count_q == CW'(WIDTH - 1)) begin
               // The MSB sum bit goes straight to the result, never via sum_sh.
               result_d       = {fa_cout_s, fa_sum_s, sum_sh_q};
               result_valid_d = 1'b1;
               busy_d         = 1'b0;
               state_d        = DONE;
            end else begin
               busy_d         = 1'b1;
            end
         end

         DONE: begin
            if (bus.result_ready) begin
               result_valid_d = 1'b0;
               start_ready_d  = 1'b1;
               state_d        = IDLE;
            end else begin
               result_valid_d = 1'b1;
            end
         end

         default: begin
            state_d        = IDLE;
            result_valid_d = 1'b0;
            start_ready_d  = 1'b1;
            busy_d         = 1'b0;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         a_sh_q         <= '0;
         b_sh_q         <= '0;
         sum_sh_q       <= '0;
         carry_q        <= 1'b0;
         count_q        <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         start_ready_q  <= 1'b1;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         a_sh_q         <= a_sh_d;
         b_sh_q         <= b_sh_d;
         sum_sh_q       <= sum_sh_d;
         carry_q        <= carry_d;
         count_q        <= count_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         start_ready_q  <= start_ready_d;
         busy_q         <= busy_d;
      end
   end

   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.start_ready  = start_ready_q;
   assign bus.busy         = busy_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=4.
// Expected subtraction results depend on whether SUBTRACT_EN is defined.
module tb_serial_adder_ctrl;
   localparam int W = 4;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one operation, check latency and result, then hand it off.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic op,
                         input logic [4:0] exp, input string tag);
      bus.a = a;
      bus.b = b;
      bus.op = op;
      bus.start_valid = 1'b1;
      tick();
      bus.start_valid = 1'b0;
      bus.a = 4'hF ^ a;
      bus.b = 4'hF ^ b;
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      check({tag, "_sready"}, {31'd0, bus.start_ready}, 32'd0);
      repeat (W - 1) tick();
      check({tag, "_early"}, {31'd0, bus.result_valid}, 32'd0);
      tick();
      check({tag, "_valid"}, {31'd0, bus.result_valid}, 32'd1);
      check({tag, "_result"}, {27'd0, bus.result}, {27'd0, exp});
      bus.result_ready = 1'b1;
      tick();
      bus.result_ready = 1'b0;
      check({tag, "_drop"}, {31'd0, bus.result_valid}, 32'd0);
      check({tag, "_idle"}, {31'd0, bus.start_ready}, 32'd1);
      check({tag, "_keep"}, {27'd0, bus.result}, {27'd0, exp});
   endtask

   logic [3:0] bb_a   [5] = '{4'd1, 4'd7, 4'd12, 4'd15, 4'd3};
   logic [3:0] bb_b   [5] = '{4'd2, 4'd8, 4'd5,  4'd1,  4'd3};
   logic [4:0] bb_exp [5] = '{5'd3, 5'd15, 5'd17, 5'd16, 5'd6};

   initial begin
      logic [4:0] sub_53;
      logic [4:0] sub_35;
      int n_acc;
      int n_res;
      int last_res;
      logic sr;

      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      bus.start_valid  = 1'b0;
      bus.result_ready = 1'b0;
      bus.a  = 4'd0;
      bus.b  = 4'd0;
      bus.op = 1'b0;

      // 1. reset state and first add
      tick();
      tick();
      reset = 1'b0;
      check("rst_sready", {31'd0, bus.start_ready}, 32'd1);
      check("rst_valid", {31'd0, bus.result_valid}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_result", {27'd0, bus.result}, 32'd0);
      run_op(4'd0, 4'd1, 1'b0, 5'b00001, "add_0_1");

      // 2. main function
      run_op(4'd9, 4'd10, 1'b0, 5'b10011, "add_9_10");
      run_op(4'd15, 4'd15, 1'b0, 5'b11110, "add_15_15");
      run_op(4'd14, 4'd15, 1'b0, 5'b11101, "add_14_15");

      // 3. backpressure in DONE
      bus.a = 4'd9;
      bus.b = 4'd10;
      bus.start_valid = 1'b1;
      tick();
      bus.start_valid = 1'b0;
      repeat (W) tick();
      for (int i = 0; i < 5; i++) begin
         bus.start_valid = i[0];
         bus.a = 4'd1;
         bus.b = 4'd1;
         tick();
         check("bp_valid", {31'd0, bus.result_valid}, 32'd1);
         check("bp_result", {27'd0, bus.result}, {27'd0, 5'b10011});
         check("bp_sready", {31'd0, bus.start_ready}, 32'd0);
      end
      bus.start_valid = 1'b0;
      bus.result_ready = 1'b1;
      tick();
      bus.result_ready = 1'b0;
      tick();
      check("bp_no_restart", {31'd0, bus.busy}, 32'd0);
      check("bp_result_after", {27'd0, bus.result}, {27'd0, 5'b10011});

      // 4. reset at the second RUN edge
      bus.a = 4'd7;
      bus.b = 4'd1;
      bus.start_valid = 1'b1;
      tick();
      bus.start_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_sready", {31'd0, bus.start_ready}, 32'd1);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_valid", {31'd0, bus.result_valid}, 32'd0);
      check("abort_result", {27'd0, bus.result}, 32'd0);
      repeat (W + 1) tick();
      check("abort_quiet", {31'd0, bus.result_valid}, 32'd0);
      run_op(4'd6, 4'd7, 1'b0, 5'b01101, "post_abort");

      // 5. subtract (or ignored op when the feature is off)
`ifdef SUBTRACT_EN
      sub_53 = 5'b10010;
      sub_35 = 5'b01110;
`else
      sub_53 = 5'b01000;
      sub_35 = 5'b01000;
`endif
      run_op(4'd5, 4'd3, 1'b1, sub_53, "op1_5_3");
      run_op(4'd3, 4'd5, 1'b1, sub_35, "op1_3_5");

      // 6. back-to-back with both handshakes tied high
      n_acc = 0;
      n_res = 0;
      last_res = -1;
      bus.op = 1'b0;
      bus.a = bb_a[0];
      bus.b = bb_b[0];
      bus.result_ready = 1'b1;
      bus.start_valid  = 1'b1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         sr = bus.start_ready;
         tick();
         if (sr) begin
            n_acc++;
            if (n_acc < 5) begin
               bus.a = bb_a[n_acc];
               bus.b = bb_b[n_acc];
            end else begin
               bus.start_valid = 1'b0;
            end
         end
         if (bus.result_valid) begin
            if (n_res < 5) begin
               check("b2b_result", {27'd0, bus.result}, {27'd0, bb_exp[n_res]});
            end else begin
               check("b2b_extra", 32'd1, 32'd0);
            end
            if (last_res >= 0) begin
               check("b2b_gap", cyc - last_res, W + 2);
            end
            last_res = cyc;
            n_res++;
         end
      end
      bus.result_ready = 1'b0;
      bus.start_valid  = 1'b0;
      check("b2b_accepts", n_acc, 32'd5);
      check("b2b_results", n_res, 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule : tb_serial_adder_ctrl
